attn_rd_streamer: RTL and testbench

Host-side reader for the flash-attention top. It kicks off an attention run, waits for the end flag, then sweeps the result BRAM blocks through the top's external read port. Each 16x128-byte block is latched and serialized onto a 128-bit valid/ready output stream. It sits between the attention top (`I_ATTN_START` / `O_ATTN_END` / `I_RD_BRAM_EN` / `I_RD_BRAM_ADDR` / `O_BRAM_RD_MAT`) and the DMA/host stream.

---
 rtl/attn_pkg.sv | 9 +
 rtl/attn_blk_serializer.sv | 66 ++++++
 rtl/attn_rd_streamer.sv | 116 +++++++++++
 tb/tb_attn_rd_streamer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// attn_pkg: shared FSM state type, block-count limits and beat-count helper for the attention read streamer
package attn_pkg;
  typedef enum logic [2:0] {IDLE, KICK, WAIT_END, RD_REQ, RD_WAIT, STREAM, DONE} attn_rd_state_e;
  localparam int ATTN_BLK_MAX = 64;
  localparam int ATTN_BLK_AW = 6;
  function automatic int beats_per_blk(input int rows, input int cols, input int beat_b);
    return rows * cols / beat_b;
  endfunction
endpackage

// File: rtl/attn_blk_serializer.sv
// attn_blk_serializer: holds one result block and plays it out as valid/ready beats
// Ports: load_i captures mat_i into the buffer; start_i arms beat 0 (may coincide with load_i);
// tlast_en_i allows tlast on this block's final beat; tdata_o/tvalid_o/tlast_o/tready_i form the
// output stream; blk_done_o is high in the cycle the block's final beat transfers.
// mat_i layout: element (r,c) at [(r*COLS+c)*D_W +: D_W], so beat b is the contiguous slice b*BEAT_B*D_W.
module attn_blk_serializer
  import attn_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int ROWS   = 16,
  parameter int COLS   = 128,
  parameter int BEAT_B = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic                       start_i,
  input  logic                       tlast_en_i,
  input  logic [ROWS*COLS*D_W-1:0]   mat_i,
  input  logic                       tready_i,
  output logic [BEAT_B*D_W-1:0]      tdata_o,
  output logic                       tvalid_o,
  output logic                       tlast_o,
  output logic                       blk_done_o
);
  localparam int BEATS = beats_per_blk(ROWS, COLS, BEAT_B);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int TW = BEAT_B * D_W;
  localparam int OW = $clog2(ROWS * COLS * D_W);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  logic [ROWS*COLS*D_W-1:0] buf_q;
  logic [BW-1:0] idx_q, nxt;
  logic [OW-1:0] off;
  logic [TW-1:0] tdata_q;
  logic tvalid_q, tlast_q, fire, last;
  assign fire = tvalid_q && tready_i;
  assign last = idx_q == LAST;
  assign nxt = idx_q + 1'b1;
  assign off = OW'(nxt) * OW'(TW);
  assign blk_done_o = fire && last;
  assign tdata_o = tdata_q;
  assign tvalid_o = tvalid_q;
  assign tlast_o = tlast_q;
  // pure storage: contents only reach the outputs after a start, so no reset is needed
  always_ff @(posedge clk) begin
    if (load_i) buf_q <= mat_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
    end else if (start_i) begin
      idx_q <= '0;
      tvalid_q <= 1'b1;
      tdata_q <= load_i ? mat_i[TW-1:0] : buf_q[TW-1:0];
      tlast_q <= tlast_en_i && LAST == '0;
    end else if (fire) begin
      idx_q <= last ? idx_q : nxt;
      tvalid_q <= !last;
      tdata_q <= last ? tdata_q : buf_q[off +: TW];
      tlast_q <= !last && tlast_en_i && nxt == LAST;
    end
  end
endmodule

// File: rtl/attn_rd_streamer.sv
// attn_rd_streamer: kicks an attention run, waits for its end flag, then reads result blocks and streams them out
// Ports: I_START/I_BLK_CNT request a run of up to 64 blocks; O_ATTN_START/I_ATTN_END talk to the attention top;
// O_RD_BRAM_EN/O_RD_BRAM_ADDR/I_BRAM_RD_MAT are its block read port (data valid RD_LAT cycles after enable);
// O_TDATA/O_TVALID/I_TREADY/O_TLAST are the output stream; O_BUSY is high outside IDLE; O_DONE pulses at run end.
// Build option: define ATTN_RD_TLAST_PER_BLK_EN to mark the last beat of every block instead of only the run's last.
module attn_rd_streamer
  import attn_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int ROWS   = 16,
  parameter int COLS   = 128,
  parameter int BEAT_B = 16,
  parameter int RD_LAT = 2
) (
  input  logic                        I_CLK,
  input  logic                        I_RST,
  input  logic                        I_START,
  input  logic [6:0]                  I_BLK_CNT,
  output logic                        O_ATTN_START,
  input  logic                        I_ATTN_END,
  output logic                        O_RD_BRAM_EN,
  output logic [ATTN_BLK_AW-1:0]      O_RD_BRAM_ADDR,
  input  logic [ROWS*COLS*D_W-1:0]    I_BRAM_RD_MAT,
  output logic [BEAT_B*D_W-1:0]       O_TDATA,
  output logic                        O_TVALID,
  input  logic                        I_TREADY,
  output logic                        O_TLAST,
  output logic                        O_BUSY,
  output logic                        O_DONE
);
  attn_rd_state_e state_q, state_d;
  logic [ATTN_BLK_AW-1:0] idx_q, idx_d, addr_q;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] wt_q, wt_d;
  logic attn_start_q, en_q, busy_q, done_q;
  logic load, more, blk_done, tlast_en;
  assign more = {1'b0, idx_q} + 7'd1 < cnt_q;
  assign load = state_q == RD_WAIT && wt_q == 3'(RD_LAT - 1);
`ifdef ATTN_RD_TLAST_PER_BLK_EN
  assign tlast_en = 1'b1;
`else
  assign tlast_en = !more;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    wt_d = wt_q;
    case (state_q)
      IDLE: begin
        cnt_d = I_START ? (I_BLK_CNT > 7'(ATTN_BLK_MAX) ? 7'(ATTN_BLK_MAX) : I_BLK_CNT) : cnt_q;
        state_d = I_START ? KICK : IDLE;
      end
      KICK: state_d = WAIT_END;
      WAIT_END: begin
        idx_d = I_ATTN_END ? '0 : idx_q;
        state_d = !I_ATTN_END ? WAIT_END : cnt_q == '0 ? DONE : RD_REQ;
      end
      RD_REQ: begin
        wt_d = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        wt_d = wt_q + 3'd1;
        state_d = load ? STREAM : RD_WAIT;
      end
      STREAM: begin
        idx_d = blk_done && more ? idx_q + 1'b1 : idx_q;
        state_d = !blk_done ? STREAM : more ? RD_REQ : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      wt_q <= '0;
      attn_start_q <= 1'b0;
      en_q <= 1'b0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      wt_q <= wt_d;
      attn_start_q <= state_d == KICK;
      en_q <= state_d == RD_REQ;
      addr_q <= idx_d;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
    end
  end
  attn_blk_serializer #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .BEAT_B(BEAT_B)) u_ser (
    .clk        (I_CLK),
    .rst        (I_RST),
    .load_i     (load),
    .start_i    (load),
    .tlast_en_i (tlast_en),
    .mat_i      (I_BRAM_RD_MAT),
    .tready_i   (I_TREADY),
    .tdata_o    (O_TDATA),
    .tvalid_o   (O_TVALID),
    .tlast_o    (O_TLAST),
    .blk_done_o (blk_done)
  );
  assign O_ATTN_START = attn_start_q;
  assign O_RD_BRAM_EN = en_q;
  assign O_RD_BRAM_ADDR = addr_q;
  assign O_BUSY = busy_q;
  assign O_DONE = done_q;
endmodule

// File: tb/tb_attn_rd_streamer.sv
// tb_attn_rd_streamer: directed self-checking bench for attn_rd_streamer with a latency-accurate block memory model
module tb_attn_rd_streamer;
  localparam int RD_LAT = 2;
  localparam int MW = 16 * 128 * 8;
  logic I_CLK = 0, I_RST = 0, I_START = 0, I_ATTN_END = 0, I_TREADY = 1;
  logic [6:0] I_BLK_CNT = '0;
  logic [MW-1:0] I_BRAM_RD_MAT = '0;
  logic O_ATTN_START, O_RD_BRAM_EN, O_TVALID, O_TLAST, O_BUSY, O_DONE;
  logic [5:0] O_RD_BRAM_ADDR;
  logic [127:0] O_TDATA;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int pc = -1, pa = 0;
  bit rnd_rdy = 0, stall = 0;
  logic [127:0] hold_d;
  logic hold_l;
  int nbeat, exp_addr, n_req, n_kick, n_done, n_tlast, n_vld, exp_total;
  int kick_cyc, req_cyc0, beat_cyc0, done_cyc, last_cyc, t, e;

  attn_rd_streamer #(.D_W(8), .ROWS(16), .COLS(128), .BEAT_B(16), .RD_LAT(RD_LAT)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_START(I_START), .I_BLK_CNT(I_BLK_CNT),
    .O_ATTN_START(O_ATTN_START), .I_ATTN_END(I_ATTN_END), .O_RD_BRAM_EN(O_RD_BRAM_EN),
    .O_RD_BRAM_ADDR(O_RD_BRAM_ADDR), .I_BRAM_RD_MAT(I_BRAM_RD_MAT), .O_TDATA(O_TDATA),
    .O_TVALID(O_TVALID), .I_TREADY(I_TREADY), .O_TLAST(O_TLAST), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // element e of block a (flat row-major index) holds (e + 3a) & 0xFF
  function automatic logic [MW-1:0] pat(input int a);
    logic [MW-1:0] m;
    for (int i = 0; i < 2048; i++) m[i*8 +: 8] = 8'((i + 3 * a) & 255);
    return m;
  endfunction

  function automatic logic [127:0] beat_exp(input int a, input int b);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'((b * 16 + k + 3 * a) & 255);
    return v;
  endfunction

  // data is correct only during the single cycle whose closing edge is the capture edge
  task automatic mem();
    if (O_RD_BRAM_EN) begin
      pc = RD_LAT;
      pa = int'(O_RD_BRAM_ADDR);
    end else if (pc >= 0) pc--;
    if (pc == 0) I_BRAM_RD_MAT = pat(pa);
    else if (pc == -1) I_BRAM_RD_MAT = ~pat(pa);
  endtask

  task automatic mon();
    logic el;
    if (O_ATTN_START) begin n_kick++; kick_cyc = cyc; end
    if (O_DONE) begin n_done++; done_cyc = cyc; end
    if (O_TVALID) n_vld++;
    if (O_RD_BRAM_EN) begin
      check("addr", O_RD_BRAM_ADDR, exp_addr);
      if (n_req == 0) req_cyc0 = cyc;
      exp_addr++;
      n_req++;
    end
    if (stall) begin
      check("hold_vld", O_TVALID, 1);
      check("hold_data", O_TDATA, hold_d);
      check("hold_last", O_TLAST, hold_l);
    end
    if (O_TVALID && I_TREADY) begin
`ifdef ATTN_RD_TLAST_PER_BLK_EN
      el = nbeat % 128 == 127;
`else
      el = nbeat == exp_total - 1;
`endif
      if (nbeat == 0) beat_cyc0 = cyc;
      check("tdata", O_TDATA, beat_exp(nbeat / 128, nbeat % 128));
      check("tlast", O_TLAST, el);
      if (O_TLAST) n_tlast++;
      last_cyc = cyc;
      nbeat++;
    end
    stall = O_TVALID && !I_TREADY;
    hold_d = O_TDATA;
    hold_l = O_TLAST;
  endtask

  task automatic cycle();
    @(negedge I_CLK);
    mon();
    mem();
    @(posedge I_CLK);
    #1;
    cyc++;
    if (rnd_rdy) I_TREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic go(input int cnt, input int dly, output int ts, output int te);
    nbeat = 0; exp_addr = 0; n_req = 0; n_kick = 0; n_done = 0; n_tlast = 0; n_vld = 0;
    stall = 0; req_cyc0 = -1; beat_cyc0 = -1; done_cyc = -1; last_cyc = -1; kick_cyc = -1;
    exp_total = (cnt > 64 ? 64 : cnt) * 128;
    I_BLK_CNT = 7'(cnt);
    I_START = 1;
    ts = cyc;
    cycle();
    I_START = 0;
    repeat (dly - 1) cycle();
    I_ATTN_END = 1;
    te = cyc;
  endtask

  task automatic fin(input int lim);
    int k = 0;
    while (n_done == 0 && k < lim) begin cycle(); k++; end
    check("done_seen", n_done, 1);
    I_ATTN_END = 0;
    repeat (3) cycle();
    check("done_once", n_done, 1);
    check("busy_idle", O_BUSY, 0);
  endtask

  initial begin
    #1 I_RST = 1;
    #1;
    check("rst_tvalid", O_TVALID, 0);
    check("rst_tdata", O_TDATA, 0);
    check("rst_addr", O_RD_BRAM_ADDR, 0);
    check("rst_busy", O_BUSY, 0);
    check("rst_done", O_DONE, 0);
    check("rst_kick", O_ATTN_START, 0);
    repeat (3) cycle();
    I_RST = 0;
    cycle();

    go(1, 20, t, e);
    check("busy_run", O_BUSY, 1);
    fin(400);
    check("kick_t", kick_cyc, t + 1);
    check("kicks", n_kick, 1);
    check("req_t", req_cyc0, e + 1);
    check("reqs1", n_req, 1);
    check("beat0_t", beat_cyc0, req_cyc0 + RD_LAT + 1);
    check("beats1", nbeat, 128);
    check("span1", last_cyc - beat_cyc0, 127);
    check("tlast1", n_tlast, 1);
    check("done_t1", done_cyc, last_cyc + 1);

    rnd_rdy = 1;
    go(2, 5, t, e);
    fin(3000);
    rnd_rdy = 0;
    I_TREADY = 1;
    check("beats2", nbeat, 256);
    check("reqs2", n_req, 2);
`ifdef ATTN_RD_TLAST_PER_BLK_EN
    check("tlast2", n_tlast, 2);
`else
    check("tlast2", n_tlast, 1);
`endif

    go(0, 10, t, e);
    fin(100);
    check("reqs0", n_req, 0);
    check("done_t0", done_cyc, e + 1);
    check("vld0", n_vld, 0);

    go(64, 3, t, e);
    fin(20000);
    check("reqs64", n_req, 64);
    check("beats64", nbeat, 8192);
    check("span64", last_cyc - beat_cyc0, 8191 + 63 * (RD_LAT + 1));
`ifdef ATTN_RD_TLAST_PER_BLK_EN
    check("tlast64", n_tlast, 64);
`else
    check("tlast64", n_tlast, 1);
`endif

    go(100, 3, t, e);
    fin(20000);
    check("reqs_sat", n_req, 64);
    check("beats_sat", nbeat, 8192);

    go(5, 4, t, e);
    begin
      int k = 0;
      while (nbeat < 3 * 128 + 40 && k < 5000) begin cycle(); k++; end
    end
    check("reach_b40", nbeat, 3 * 128 + 40);
    I_RST = 1;
    #1;
    check("mid_tvalid", O_TVALID, 0);
    check("mid_tdata", O_TDATA, 0);
    check("mid_tlast", O_TLAST, 0);
    check("mid_busy", O_BUSY, 0);
    check("mid_en", O_RD_BRAM_EN, 0);
    check("mid_addr", O_RD_BRAM_ADDR, 0);
    check("mid_done", O_DONE, 0);
    check("mid_kick", O_ATTN_START, 0);
    pc = -1;
    stall = 0;
    I_ATTN_END = 0;
    repeat (2) cycle();
    I_RST = 0;
    cycle();
    go(2, 4, t, e);
    fin(1000);
    check("re_reqs", n_req, 2);
    check("re_beats", nbeat, 256);
    check("re_kicks", n_kick, 1);

    go(1, 4, t, e);
    begin
      int k = 0;
      while (nbeat < 10 && k < 100) begin cycle(); k++; end
    end
    I_START = 1;
    I_ATTN_END = 0;
    cycle();
    I_START = 0;
    fin(400);
    repeat (20) cycle();
    check("ign_kicks", n_kick, 1);
    check("ign_reqs", n_req, 1);
    check("ign_beats", nbeat, 128);
    check("ign_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
